set_pipe_exec: RTL
==================

Name: set_pipe_exec

Overview:
Parametrised, pipelined execution unit for the register-immediate "set" instruction class of the simple pipeline ILA model. It generalises single-cycle SET decode in three ways: parametrised register count and data width, a 4-op mode field (NOP/SET/SETHI/ADDI), and a two-stage pipeline with valid/ready intake, stall, and S2→S1 bypass. It owns the architectural register file and exports it flattened for refinement-map checking against the ILA.

Parameters:
NREG, 4, number of architectural registers; power of 2, ≥2
DW, 8, register data width
IMMW, 4, immediate field width; 1 ≤ IMMW ≤ DW
(derived) RW = log2(NREG); IW = 2+IMMW+RW; defaults give RW=2, IW=8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  instruction offered
in_ready  out  1  unit accepts the instruction this cycle
inst  in  IW  instruction: [IW-1:IW-2]=op, [RW+IMMW-1:RW]=imm, [RW-1:0]=rd
stall  in  1  freeze whole pipeline
wb_valid  out  1  regfile write committed at the last edge
wb_idx  out  RW  index written
wb_data  out  DW  value written
regs_flat  out  NREG*DW  register file; reg i at [i*DW+DW-1:i*DW]

Behaviour:
- Ops: 00 NOP (no write); 01 SET rd=ext(imm); 10 SETHI rd={imm, rd[DW-IMMW-1:0]} (imm in top IMMW bits, low bits kept; if IMMW==DW, rd=imm); 11 ADDI rd=rd+ext(imm) mod 2^DW, carry dropped. ext = zero-extend by default.
- in_ready = !stall. Accept = in_valid & in_ready at an edge.
- S1 (decode): on accept, latch op/imm/rd and set s1_v=1; no accept and no stall → s1_v=0. NOP still occupies S1 but produces s2_v=0.
- Compute (combinational, from S1): source rd value = S2 result if s2_v && s2_idx==s1_rd (bypass), else regfile[s1_rd].
- S2: at edge with !stall, s2_v = s1_v && op!=NOP; latch idx and result.
- Commit: at edge with !stall and s2_v, regfile[s2_idx] = s2_data; same edge sets wb_valid=1, wb_idx, wb_data; otherwise wb_valid=0.
- Latency: accepted at edge E0 → regs_flat/wb_* reflect it after E2. Throughput 1/cycle; back-to-back same-rd correct via bypass.
- stall=1: S1, S2, regfile, wb_idx, wb_data all hold; wb_valid=0; in_ready=0.
- Reset (rst_n=0 at edge): all regs, s1_v, s2_v, wb_valid, wb_idx, wb_data = 0. Mid-operation reset discards in-flight instructions; no partial commit. in_ready follows stall during reset, but nothing accepted at a reset edge is retained.
- Only one write per edge, so no write conflicts.

Optional Feature:
SET_SIGN_EXT_EN: defined → ext() sign-extends imm for SET and ADDI (SETHI unaffected). Undefined → zero-extend, matching the base ILA SET semantics.

Decomposition:
- Package set_pipe_pkg: op encodings (OP_NOP/OP_SET/OP_SETHI/OP_ADDI), instruction field-offset functions of IMMW/RW, ext() function honoring SET_SIGN_EXT_EN.
- One combinational sub-module set_pipe_alu: (op, imm, src) → result; pipeline, bypass, and regfile stay in the top.

Test Plan (defaults):
- Reset, then inst=0x55 (SET r1,5) → after 2 edges wb_valid=1, wb_idx=1, wb_data=0x05, r1=0x05, other regs 0.
- Back-to-back 0x55, 0xA9 (SETHI r1,0xA), 0xFD (ADDI r1,0xF) → r1 goes 0x05, 0xA5, 0xB4 on consecutive cycles (exercises bypass).
- SET r3,0xF (0x7F), SETHI r3,0xF (0xBF), ADDI r3,1 (0xC7) → r3 = 0x0F, 0xFF, then 0x00 (wrap).
- SET r2,0xC (0x72) → r2=0x0C without macro, 0xFC with SET_SIGN_EXT_EN.
- Assert stall for 3 cycles with 2 instructions in flight → in_ready=0, wb_valid=0, regs unchanged; after release both commit in order; NOP (0x00) produces no wb_valid.
- Pulse rst_n=0 with S1 and S2 full → all regs 0, no wb_valid after reset; the next instruction executes normally.

Source files
------------

// File: rtl/set_pipe_exec_pkg.sv
// Shared definitions for the set-instruction pipeline: op encodings, instruction
// field offsets and immediate extension.
// Optional feature macro: SET_SIGN_EXT_EN (sign-extend immediates for SET/ADDI).
package set_pipe_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_SETHI = 2'b10,
    OP_ADDI  = 2'b11
  } op_t;

  // Widest immediate/data path ext() can serve; callers truncate to DW.
  localparam int MAXW = 64;

  // Instruction layout: {op[1:0], imm[IMMW-1:0], rd[RW-1:0]}.
  function automatic int op_lsb(input int immw, input int rw);
    return immw + rw;
  endfunction

  function automatic int imm_lsb(input int rw);
    return rw;
  endfunction

  // Extend an IMMW-bit immediate to MAXW bits. Zero-extension matches the base
  // ILA semantics; the sign-extending build replicates imm[immw-1].
  function automatic logic [MAXW-1:0] ext(input logic [MAXW-1:0] imm, input int immw);
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < immw) begin
        r[i] = imm[i];
      end
`ifdef SET_SIGN_EXT_EN
      else if (immw > 0) begin
        r[i] = imm[immw-1];
      end
`endif
    end
    return r;
  endfunction

endpackage

// File: rtl/set_pipe_exec_if.sv
// Instruction intake and writeback bundle of the set-instruction pipeline.
// Ports: in_valid/in_ready/inst/stall (towards the unit), wb_valid/wb_idx/wb_data (from it).
// Modports: master = instruction source / observer, slave = execution unit.
interface set_pipe_exec_if #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  parameter int IMMW = 4
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 2 + IMMW + RW;

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] inst;
  logic          stall;
  logic          wb_valid;
  logic [RW-1:0] wb_idx;
  logic [DW-1:0] wb_data;

  modport master (
    output in_valid, inst, stall,
    input  in_ready, wb_valid, wb_idx, wb_data
  );

  modport slave (
    input  in_valid, inst, stall,
    output in_ready, wb_valid, wb_idx, wb_data
  );

endinterface

// File: rtl/set_pipe_exec_alu.sv
// Combinational result generator for NOP/SET/SETHI/ADDI.
// Ports: op, imm (IMMW), src (current rd value, DW) -> result (DW).
// Extension mode follows SET_SIGN_EXT_EN via set_pipe_pkg::ext().
module set_pipe_alu
  import set_pipe_pkg::*;
#(
  parameter int DW   = 8,
  parameter int IMMW = 4
) (
  input  op_t             op,
  input  logic [IMMW-1:0] imm,
  input  logic [DW-1:0]   src,
  output logic [DW-1:0]   result
);

  logic [DW-1:0] imm_ext;
  logic [DW-1:0] hi_val;

  assign imm_ext = DW'(ext(MAXW'(imm), IMMW));

  // SETHI places imm in the top bits and keeps the low bits of rd.
  generate
    if (IMMW == DW) begin : g_hi_full
      assign hi_val = imm;
    end else begin : g_hi_part
      assign hi_val = {imm, src[DW-IMMW-1:0]};
    end
  endgenerate

  always_comb begin
    result = src;
    case (op)
      OP_SET:   result = imm_ext;
      OP_SETHI: result = hi_val;
      OP_ADDI:  result = src + imm_ext;
      default:  result = src;
    endcase
  end

endmodule

// File: rtl/set_pipe_exec.sv
// Two-stage execution unit for register-immediate set instructions; owns the regfile.
// Ports: clk, rst_n (sync, active-low), bus (set_pipe_exec_if.slave), regs_flat (NREG*DW).
// Accept -> S1 (decode) -> S2 (result) -> commit; S2->S1 bypass; stall freezes all state.
// Optional macro: SET_SIGN_EXT_EN (handled inside set_pipe_pkg::ext()).
module set_pipe_exec
  import set_pipe_pkg::*;
#(
  parameter int NREG = 4,
  parameter int DW   = 8,
  parameter int IMMW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  set_pipe_exec_if.slave       bus,
  output logic [NREG*DW-1:0]   regs_flat
);

  localparam int RW      = $clog2(NREG);
  localparam int OP_LSB  = op_lsb(IMMW, RW);
  localparam int IMM_LSB = imm_lsb(RW);

  logic [DW-1:0]   rf [NREG];

  logic            s1_v;
  op_t             s1_op;
  logic [IMMW-1:0] s1_imm;
  logic [RW-1:0]   s1_rd;

  logic            s2_v;
  logic [RW-1:0]   s2_idx;
  logic [DW-1:0]   s2_data;

  logic            wb_valid_q;
  logic [RW-1:0]   wb_idx_q;
  logic [DW-1:0]   wb_data_q;

  logic            accept;
  logic [DW-1:0]   src_val;
  logic [DW-1:0]   alu_res;

  assign bus.in_ready = !bus.stall;
  assign accept       = bus.in_valid && !bus.stall;

  // The S2 result has not reached the regfile yet, so a dependent S1 takes it directly.
  assign src_val = (s2_v && (s2_idx == s1_rd)) ? s2_data : rf[s1_rd];

  set_pipe_alu #(
    .DW   (DW),
    .IMMW (IMMW)
  ) u_alu (
    .op     (s1_op),
    .imm    (s1_imm),
    .src    (src_val),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      s1_v       <= 1'b0;
      s1_op      <= OP_NOP;
      s1_imm     <= '0;
      s1_rd      <= '0;
      s2_v       <= 1'b0;
      s2_idx     <= '0;
      s2_data    <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
    end else if (bus.stall) begin
      // Everything holds; only the commit strobe drops.
      wb_valid_q <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_op  <= op_t'(bus.inst[OP_LSB +: 2]);
        s1_imm <= bus.inst[IMM_LSB +: IMMW];
        s1_rd  <= bus.inst[RW-1:0];
      end

      // A NOP travels through S1 but never becomes a write.
      s2_v    <= s1_v && (s1_op != OP_NOP);
      s2_idx  <= s1_rd;
      s2_data <= alu_res;

      wb_valid_q <= s2_v;
      if (s2_v) begin
        rf[s2_idx] <= s2_data;
        wb_idx_q   <= s2_idx;
        wb_data_q  <= s2_data;
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_idx   = wb_idx_q;
  assign bus.wb_data  = wb_data_q;

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[g*DW +: DW] = rf[g];
    end
  endgenerate

endmodule
